// File: rtl/vga_sprite_overlay.sv
// Sprite overlay: composites a solid-colour movable box onto a VGA pixel stream.
// Position moves on a periodic tick from direction buttons and is latched into
// the displayed position only at the start of a frame (falling edge of iVS).
module vga_sprite_overlay #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned SPRITE_W   = 30,
    parameter int unsigned SPRITE_H   = 30,
    parameter int unsigned STEP_DIV   = 25000,
    parameter int unsigned STEP_PX    = 1,
    parameter logic [23:0] SPRITE_BGR = 24'h000ABC,
    parameter int unsigned WRAP_MODE  = 0
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        iBLANK_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic [23:0] iBGR,
    output logic [23:0] oBGR,
    output logic        oBLANK_n,
    output logic        oHS,
    output logic        oVS,
    output logic [9:0]  oX,
    output logic [8:0]  oY
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned CW = $clog2(STEP_DIV);

    // One extra bit so sums and comparisons never overflow
    typedef logic [XW:0] xw_t;
    typedef logic [YW:0] yw_t;

    localparam xw_t XMAX = xw_t'(H_ACTIVE - SPRITE_W);
    localparam yw_t YMAX = yw_t'(V_ACTIVE - SPRITE_H);

    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] tick_cnt;
    logic          tick_c;
    logic          vs_q;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [XW-1:0] nx_next_c;
    logic [YW-1:0] ny_next_c;
    xw_t           x_sum_c;
    yw_t           y_sum_c;
    logic          inside_c;

    assign tick_c = (tick_cnt == CW'(STEP_DIV - 1));

    // Pixel position counters, cleared during vertical sync
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            px <= '0;
            py <= '0;
        end else if (!iVS) begin
            px <= '0;
            py <= '0;
        end else if (iBLANK_n) begin
            if (px == XW'(H_ACTIVE - 1)) begin
                px <= '0;
                py <= py + YW'(1);
            end else begin
                px <= px + XW'(1);
            end
        end
    end

    // Movement tick divider
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // Next horizontal pending position: opposing buttons cancel; clamp or wrap at edges
    always_comb begin
        nx_next_c = nx;
        x_sum_c   = {1'b0, nx} + xw_t'(STEP_PX);
        if (right && !left) begin
            if (x_sum_c > XMAX) begin
                nx_next_c = (WRAP_MODE != 0) ? '0 : XMAX[XW-1:0];
            end else begin
                nx_next_c = x_sum_c[XW-1:0];
            end
        end else if (left && !right) begin
            if ({1'b0, nx} < xw_t'(STEP_PX)) begin
                nx_next_c = (WRAP_MODE != 0) ? XMAX[XW-1:0] : '0;
            end else begin
                nx_next_c = nx - XW'(STEP_PX);
            end
        end
    end

    // Next vertical pending position: down is positive
    always_comb begin
        ny_next_c = ny;
        y_sum_c   = {1'b0, ny} + yw_t'(STEP_PX);
        if (down && !up) begin
            if (y_sum_c > YMAX) begin
                ny_next_c = (WRAP_MODE != 0) ? '0 : YMAX[YW-1:0];
            end else begin
                ny_next_c = y_sum_c[YW-1:0];
            end
        end else if (up && !down) begin
            if ({1'b0, ny} < yw_t'(STEP_PX)) begin
                ny_next_c = (WRAP_MODE != 0) ? YMAX[YW-1:0] : '0;
            end else begin
                ny_next_c = ny - YW'(STEP_PX);
            end
        end
    end

    // Pending position: buttons are only looked at on tick clocks
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            nx <= '0;
            ny <= '0;
        end else if (tick_c) begin
            nx <= nx_next_c;
            ny <= ny_next_c;
        end
    end

    // Frame commit: the drawn position takes the pre-tick pending value on the iVS fall
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_q <= 1'b1;
            oX   <= '0;
            oY   <= '0;
        end else begin
            vs_q <= iVS;
            if (vs_q && !iVS) begin
                oX <= nx;
                oY <= ny;
            end
        end
    end

    // Sprite hit test on the current pixel
    always_comb begin
        inside_c = ({1'b0, px} >= {1'b0, oX}) &&
                   ({1'b0, px} <  ({1'b0, oX} + xw_t'(SPRITE_W))) &&
                   ({1'b0, py} >= {1'b0, oY}) &&
                   ({1'b0, py} <  ({1'b0, oY} + yw_t'(SPRITE_H)));
    end

    // Composite pixel and delay timing by one clock to stay aligned
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oBGR     <= '0;
            oBLANK_n <= 1'b0;
            oHS      <= 1'b1;
            oVS      <= 1'b1;
        end else begin
            if (!iBLANK_n) begin
                oBGR <= '0;
            end else if (inside_c) begin
                oBGR <= SPRITE_BGR;
            end else begin
                oBGR <= iBGR;
            end
            oBLANK_n <= iBLANK_n;
            oHS      <= iHS;
            oVS      <= iVS;
        end
    end

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for vga_sprite_overlay on a 16x8 screen with a 4x2 sprite;
// a clamp-mode and a wrap-mode instance share the same stimulus.
module tb_vga_sprite_overlay;

    localparam logic [23:0] SPR = 24'h000ABC;
    localparam logic [23:0] BG  = 24'h123456;
    localparam int NVEC = 2 + 8 * 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        up, down, left, right;
    logic        iBLANK_n, iHS, iVS;
    logic [23:0] iBGR;
    logic [23:0] oBGR, w_bgr;
    logic        oBLANK_n, oHS, oVS, w_blank, w_hs, w_vs;
    logic [9:0]  oX, w_x;
    logic [8:0]  oY, w_y;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    typedef struct {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [23:0] bgr;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    vga_sprite_overlay #(
        .H_ACTIVE(16), .V_ACTIVE(8), .SPRITE_W(4), .SPRITE_H(2),
        .STEP_DIV(4), .STEP_PX(3), .SPRITE_BGR(SPR), .WRAP_MODE(0)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .iBLANK_n(iBLANK_n), .iHS(iHS), .iVS(iVS), .iBGR(iBGR),
        .oBGR(oBGR), .oBLANK_n(oBLANK_n), .oHS(oHS), .oVS(oVS),
        .oX(oX), .oY(oY)
    );

    vga_sprite_overlay #(
        .H_ACTIVE(16), .V_ACTIVE(8), .SPRITE_W(4), .SPRITE_H(2),
        .STEP_DIV(4), .STEP_PX(3), .SPRITE_BGR(SPR), .WRAP_MODE(1)
    ) dut_w (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .iBLANK_n(iBLANK_n), .iHS(iHS), .iVS(iVS), .iBGR(iBGR),
        .oBGR(w_bgr), .oBLANK_n(w_blank), .oHS(w_hs), .oVS(w_vs),
        .oX(w_x), .oY(w_y)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_to(input int n);
        while (cyc_n < n) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        iBLANK_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBGR = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_n = 0;
    endtask

    // One frame: 2 vsync clocks, then 8 lines of 16 active + 4 blanking clocks
    task automatic fill_frame(input int sx, input int sy);
        int k;
        logic [23:0] e;
        k = 0;
        for (int v = 0; v < 2; v++) begin
            tbl[k] = '{1'b0, 1'b1, 1'b0, 24'hFFFFFF, {24'h0, 1'b0, 1'b1, 1'b0}};
            k++;
        end
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                e = (x >= sx && x < sx + 4 && y >= sy && y < sy + 2) ? SPR : BG;
                tbl[k] = '{1'b1, 1'b1, 1'b1, BG, {e, 1'b1, 1'b1, 1'b1}};
                k++;
            end
            for (int b = 0; b < 4; b++) begin
                logic h;
                h = (b == 1 || b == 2) ? 1'b0 : 1'b1;
                tbl[k] = '{1'b0, h, 1'b1, 24'hFFFFFF, {24'h0, 1'b0, h, 1'b1}};
                k++;
            end
        end
    endtask

    task automatic run_frame(input string nm);
        for (int i = 0; i < NVEC; i++) begin
            iBLANK_n = tbl[i].blank_n;
            iHS      = tbl[i].hs;
            iVS      = tbl[i].vs;
            iBGR     = tbl[i].bgr;
            cyc();
            chk($sformatf("%s[%0d]", nm, i), 64'({oBGR, oBLANK_n, oHS, oVS}), 64'(tbl[i].exp));
        end
        iBLANK_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBGR = '0;
    endtask

    initial begin
        int exp_c[5];
        int exp_w[5];
        exp_c = '{3, 6, 9, 12, 12};
        exp_w = '{3, 6, 9, 12, 0};

        // Reset values and a frame with the sprite at the origin
        do_reset();
        chk("rst_oX", 64'(oX), 64'd0);
        chk("rst_oHS", 64'(oHS), 64'd1);
        chk("rst_oBLANK", 64'(oBLANK_n), 64'd0);
        fill_frame(0, 0);
        run_frame("frame00");

        // Right held: clamp vs wrap pending positions, drawn position held
        do_reset();
        right = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            run_to(4 * k);
            chk($sformatf("nx_clamp_t%0d", k), 64'(dut.nx), 64'(exp_c[k-1]));
            chk($sformatf("nx_wrap_t%0d", k), 64'(dut_w.nx), 64'(exp_w[k-1]));
            chk($sformatf("oX_hold_t%0d", k), 64'(oX), 64'd0);
        end
        right = 1'b0;
        iVS = 1'b0;
        cyc();
        chk("commit_clamp_oX", 64'(oX), 64'd12);
        chk("commit_wrap_oX", 64'(w_x), 64'd0);
        iVS = 1'b1;
        run_to(23);
        left = 1'b1;
        cyc();
        chk("left_clamp_nx", 64'(dut.nx), 64'd9);
        chk("left_wrap_nx", 64'(dut_w.nx), 64'd12);
        left = 1'b0;
        up = 1'b1;
        run_to(28);
        chk("up_clamp_ny", 64'(dut.ny), 64'd0);
        chk("up_wrap_ny", 64'(dut_w.ny), 64'd6);
        chk("oX_no_commit", 64'(oX), 64'd12);
        up = 1'b0;

        // Left+right cancel, down to the bottom edge
        do_reset();
        left = 1'b1; right = 1'b1; down = 1'b1;
        run_to(4);
        chk("lr_nx_t1", 64'(dut.nx), 64'd0);
        chk("down_ny_t1", 64'(dut.ny), 64'd3);
        run_to(8);
        chk("down_ny_t2", 64'(dut.ny), 64'd6);
        run_to(12);
        chk("down_ny_t3", 64'(dut.ny), 64'd6);
        chk("lr_nx_t3", 64'(dut.nx), 64'd0);
        chk("down_wrap_ny_t3", 64'(dut_w.ny), 64'd0);
        left = 1'b0; right = 1'b0; down = 1'b0;
        fill_frame(0, 6);
        run_frame("frame06");
        chk("frame06_oY", 64'(oY), 64'd6);

        // Tick on the commit clock: old value drawn now, new value next frame
        do_reset();
        right = 1'b1;
        run_to(8);
        chk("pre_nx", 64'(dut.nx), 64'd6);
        run_to(11);
        iVS = 1'b0;
        cyc();
        chk("coincide_nx", 64'(dut.nx), 64'd9);
        chk("coincide_oX", 64'(oX), 64'd6);
        right = 1'b0;
        iVS = 1'b1;
        repeat (3) cyc();
        chk("midframe_oX", 64'(oX), 64'd6);
        iVS = 1'b0;
        cyc();
        chk("next_frame_oX", 64'(oX), 64'd9);
        iVS = 1'b1;
        cyc();
        fill_frame(9, 0);
        run_frame("frame90");
        chk("frame90_oX", 64'(oX), 64'd9);

        // Asynchronous reset mid-line
        iBLANK_n = 1'b1; iHS = 1'b0; iVS = 1'b1; iBGR = BG;
        cyc();
        chk("preline_bgr", 64'(oBGR), 64'(BG));
        chk("preline_hs", 64'(oHS), 64'd0);
        rst_n = 1'b0;
        #2;
        chk("arst_oX", 64'(oX), 64'd0);
        chk("arst_oY", 64'(oY), 64'd0);
        chk("arst_bgr", 64'(oBGR), 64'd0);
        chk("arst_hs", 64'(oHS), 64'd1);
        chk("arst_vs", 64'(oVS), 64'd1);
        chk("arst_blank", 64'(oBLANK_n), 64'd0);
        chk("arst_wrap", 64'({w_x, w_y, w_bgr, w_blank, w_hs, w_vs}),
            64'({10'd0, 9'd0, 24'd0, 1'b0, 1'b1, 1'b1}));
        @(posedge clk);
        #1;
        iBLANK_n = 1'b0; iHS = 1'b1; iBGR = '0;
        rst_n = 1'b1;
        cyc_n = 0;
        right = 1'b1;
        run_to(3);
        chk("rel_nx_c3", 64'(dut.nx), 64'd0);
        run_to(4);
        chk("rel_nx_c4", 64'(dut.nx), 64'd3);
        run_to(8);
        chk("rel_nx_c8", 64'(dut.nx), 64'd6);
        chk("rel_oX_held", 64'(oX), 64'd0);
        right = 1'b0;
        iVS = 1'b0;
        cyc();
        chk("rel_commit_oX", 64'(oX), 64'd6);
        iVS = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
